alu_exec_responder: RTL and testbench
=====================================

Name: alu_exec_responder

Overview:
Registered, handshaked execute unit that answers operation requests (ALUControl, A, B) with ALUResult/Zero.
- Wraps the existing ALU operation set and adds an iterative unsigned 32x32 multiply with a HI/LO result.
- Sits between the decode/issue logic (the requester) and writeback in the pipelined datapath.
- The requester stalls on ReqReady, so multi-cycle operations need no hazard logic elsewhere.

Parameters:
- DATA_W, 32: operand and result width.
- MUL_EN, 1: 1 = multiply opcode supported; 0 = multiply opcode treated as illegal.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  synchronous, active-low reset.
- ReqValid  in  1  request present on ALUControl/A/B.
- ReqReady  out  1  unit can accept a request this cycle.
- ALUControl  in  4  operation code.
- A  in  DATA_W  operand A.
- B  in  DATA_W  operand B.
- RespValid  out  1  response fields are valid.
- RespReady  in  1  consumer takes the response this cycle.
- ALUResult  out  DATA_W  result (LO word for multiply).
- Hi  out  DATA_W  upper product word for multiply; 0 for all other ops.
- Zero  out  1  1 iff ALUResult == 0.
- OpErr  out  1  illegal opcode was received.

Behaviour:
- Clock and reset: one clock, Clk. Rst_n is synchronous and active-low.
- Reset: state=IDLE; RespValid, ALUResult, Hi, Zero and OpErr all 0. ReqReady is 0 while Rst_n=0.
- Reset asserted mid-operation aborts any multiply or pending response with no output event.
- FSM states: IDLE, MUL, RESP.
- ReqReady = (state==IDLE) && Rst_n. A request is accepted on any cycle with ReqValid && ReqReady; operands and opcode are captured then.
- Single-cycle opcodes, IDLE->RESP, response registered the cycle after acceptance (latency 1):
  - 0000 AND
  - 0001 OR
  - 0010 ADD (wraps mod 2^DATA_W, no overflow flag)
  - 0110 SUB (wraps)
  - 0111 SLT (signed compare; result 1 or 0)
- 1000 MULTU (MUL_EN=1): IDLE->MUL.
  - Shift-add, one multiplier bit per cycle, 6-bit iteration counter, exactly DATA_W cycles in MUL, then RESP.
  - RespValid rises DATA_W+1 cycles after acceptance.
  - {Hi, ALUResult} = A*B, unsigned, 2*DATA_W bits.
- Any other opcode, or 1000 with MUL_EN=0: IDLE->RESP with ALUResult=0, Hi=0, Zero=1, OpErr=1, latency 1.
- RESP: RespValid=1; all response fields held stable until RespReady=1; on that cycle go to IDLE and drop RespValid next cycle.
- Back-to-back: ReqReady=0 in RESP, so a new request is accepted no earlier than the cycle after the response handshake. Single-cycle throughput is one op per 2 cycles when RespReady is held high.
- Zero is computed from the registered result only, never combinationally from the inputs.
- Hi and OpErr are cleared on the next accepted request that does not set them.
- ReqValid while busy is ignored. The requester must hold its request until ReqReady.
- Input changes while not accepted have no effect on outputs.

Decomposition:
- Shared package alu_pkg:
  - ALUControl opcode constants (ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_MULTU=4'b1000).
  - FSM state encoding.
- One sub-module: mul_iter_unit.
  - Start/done handshake, 64-bit accumulator, counter.
  - Instantiated only when MUL_EN=1.
- Logic ops, add/sub/slt and Zero stay in the top module.

Test Plan:
- Reset then A=1, B=2, ALUControl=0010, ReqValid=1, RespReady=1 -> one cycle later RespValid=1, ALUResult=3, Zero=0, Hi=0, OpErr=0.
- A=1, B=1, op 0110 -> ALUResult=0, Zero=1. Then A=1, B=2, op 0111 -> ALUResult=1. Then A=32'hFFFFFFFF, B=1, op 0111 -> ALUResult=1 (signed -1<1).
- A=32'hFFFFFFFF, B=2, op 1000 -> ReqReady=0 for 32 cycles, RespValid at cycle 33, Hi=1, ALUResult=32'hFFFFFFFE, Zero=0.
- Hold RespReady=0 for 5 cycles after an AND of A=1, B=0 -> RespValid stays 1, ALUResult=0 and Zero=1 stable, ReqValid ignored. Release -> IDLE next cycle.
- Opcode 4'b1111 -> OpErr=1, ALUResult=0, Zero=1, latency 1.
- Assert Rst_n=0 at cycle 10 of a multiply -> next cycle RespValid=0, all outputs 0. After release, an OR of A=0, B=0 returns Zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM state encoding shared by the execute unit
package alu_pkg;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESP} state_t;
endpackage

// File: rtl/mul_iter_unit.sv
// mul_iter_unit: shift-add unsigned multiplier, one multiplier bit per cycle
module mul_iter_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);
  logic                busy;
  logic [5:0]          cnt;
  logic [DATA_W-1:0]   mcand;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W:0]     sum;
  // product is the accumulator after this cycle's step, so the final
  // value is visible in the same cycle done is raised
  always_comb begin
    sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
    product = {sum, acc[DATA_W-1:1]};
    done    = busy && cnt == 6'(DATA_W-1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      mcand <= a;
      acc   <= {{DATA_W{1'b0}}, b};
    end else if (busy) begin
      acc  <= product;
      cnt  <= cnt + 6'd1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/alu_exec_responder.sv
// alu_exec_responder: handshaked execute unit with single-cycle ALU ops and
// an iterative unsigned multiply producing a HI/LO result
module alu_exec_responder
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [3:0]        ALUControl,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] Hi,
  output logic              Zero,
  output logic              OpErr
);
  state_t              state;
  logic                accept;
  logic                is_mul;
  logic                legal;
  logic [DATA_W-1:0]   res;
  logic                mul_done;
  logic [2*DATA_W-1:0] prod;
  assign ReqReady = state == S_IDLE && Rst_n;
  assign accept   = ReqValid && ReqReady;
  always_comb begin
    is_mul = MUL_EN && ALUControl == ALU_MULTU;
    legal  = ALUControl inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
    res    = ALUControl == ALU_AND ? A & B :
             ALUControl == ALU_OR  ? A | B :
             ALUControl == ALU_ADD ? A + B :
             ALUControl == ALU_SUB ? A - B :
             ALUControl == ALU_SLT ? {{(DATA_W-1){1'b0}}, $signed(A) < $signed(B)} : '0;
  end
  if (MUL_EN) begin : g_mul
    mul_iter_unit #(.DATA_W(DATA_W)) u_mul (
      .clk(Clk),
      .rst_n(Rst_n),
      .start(accept && is_mul),
      .a(A),
      .b(B),
      .done(mul_done),
      .product(prod)
    );
  end else begin : g_nomul
    assign mul_done = 1'b0;
    assign prod     = '0;
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      RespValid <= 1'b0;
      ALUResult <= '0;
      Hi        <= '0;
      Zero      <= 1'b0;
      OpErr     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          OpErr <= !legal && !is_mul;
          if (is_mul) state <= S_MUL;
          else begin
            state     <= S_RESP;
            RespValid <= 1'b1;
            ALUResult <= res;
            Hi        <= '0;
            Zero      <= res == '0;
          end
        end
        S_MUL: if (mul_done) begin
          state     <= S_RESP;
          RespValid <= 1'b1;
          ALUResult <= prod[DATA_W-1:0];
          Hi        <= prod[2*DATA_W-1:DATA_W];
          Zero      <= prod[DATA_W-1:0] == '0;
        end
        default: if (RespReady) begin
          state     <= S_IDLE;
          RespValid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_responder.sv
// tb_alu_exec_responder: directed self-checking bench for alu_exec_responder
module tb_alu_exec_responder;
  logic        Clk = 1'b0;
  logic        Rst_n, ReqValid, ReqReady, RespValid, RespReady, Zero, OpErr;
  logic [3:0]  ALUControl;
  logic [31:0] A, B, ALUResult, Hi;
  int checks = 0;
  int errors = 0;

  alu_exec_responder #(.DATA_W(32), .MUL_EN(1'b1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ALUControl(ALUControl), .A(A), .B(B), .RespValid(RespValid),
    .RespReady(RespReady), .ALUResult(ALUResult), .Hi(Hi), .Zero(Zero), .OpErr(OpErr)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUControl = op;
    A = a;
    B = b;
    ReqValid = 1'b1;
    tick();
    ReqValid = 1'b0;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 40 && !RespValid; i++) tick();
    chk("resp_timeout", RespValid, 1);
  endtask

  task automatic resp(input string tag, input logic [31:0] res, input logic [31:0] hi,
                      input logic z, input logic err);
    chk({tag, "_valid"}, RespValid, 1);
    chk({tag, "_result"}, ALUResult, res);
    chk({tag, "_hi"}, Hi, hi);
    chk({tag, "_zero"}, Zero, z);
    chk({tag, "_operr"}, OpErr, err);
  endtask

  initial begin
    Rst_n = 1'b0; ReqValid = 1'b0; RespReady = 1'b1;
    ALUControl = 4'b0000; A = '0; B = '0;
    tick(); tick();
    chk("rst_valid", RespValid, 0);
    chk("rst_ready", ReqReady, 0);
    chk("rst_result", ALUResult, 0);
    chk("rst_hi", Hi, 0);
    chk("rst_zero", Zero, 0);
    chk("rst_operr", OpErr, 0);
    Rst_n = 1'b1;
    #1;
    chk("idle_ready", ReqReady, 1);

    issue(4'b0010, 32'd1, 32'd2);
    resp("add", 32'd3, 32'd0, 1'b0, 1'b0);
    chk("resp_not_ready", ReqReady, 0);
    tick();
    chk("add_done_valid", RespValid, 0);
    chk("add_done_ready", ReqReady, 1);

    issue(4'b0110, 32'd1, 32'd1);
    resp("sub", 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    issue(4'b0111, 32'd1, 32'd2);
    resp("slt_pos", 32'd1, 32'd0, 1'b0, 1'b0);
    tick();
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    resp("slt_neg", 32'd1, 32'd0, 1'b0, 1'b0);
    tick();
    issue(4'b0111, 32'd2, 32'd1);
    resp("slt_false", 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    issue(4'b0001, 32'hF0F0_0000, 32'h0000_0F0F);
    resp("or", 32'hF0F0_0F0F, 32'd0, 1'b0, 1'b0);
    tick();

    issue(4'b1000, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 32; i++) begin
      chk("mul_busy_valid", RespValid, 0);
      chk("mul_busy_ready", ReqReady, 0);
      tick();
    end
    resp("mul_ff_2", 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0);
    tick();

    issue(4'b1000, 32'h0001_0000, 32'h0001_0000);
    wait_resp();
    resp("mul_2p32", 32'd0, 32'd1, 1'b1, 1'b0);
    tick();
    issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp();
    resp("mul_max", 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    tick();

    issue(4'b1111, 32'd7, 32'd9);
    resp("illegal", 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    issue(4'b0010, 32'd2, 32'd3);
    resp("add_clears_err", 32'd5, 32'd0, 1'b0, 1'b0);
    tick();

    RespReady = 1'b0;
    issue(4'b0000, 32'd1, 32'd0);
    resp("and", 32'd0, 32'd0, 1'b1, 1'b0);
    ALUControl = 4'b0010; A = 32'd5; B = 32'd6; ReqValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", RespValid, 1);
      chk("hold_result", ALUResult, 0);
      chk("hold_zero", Zero, 1);
      chk("hold_ready", ReqReady, 0);
    end
    ReqValid = 1'b0;
    RespReady = 1'b1;
    tick();
    chk("release_valid", RespValid, 0);
    chk("release_ready", ReqReady, 1);
    chk("release_result", ALUResult, 0);

    issue(4'b1000, 32'd3, 32'd5);
    repeat (9) tick();
    chk("mid_mul_valid", RespValid, 0);
    Rst_n = 1'b0;
    tick();
    chk("abort_valid", RespValid, 0);
    chk("abort_ready", ReqReady, 0);
    chk("abort_result", ALUResult, 0);
    chk("abort_hi", Hi, 0);
    chk("abort_zero", Zero, 0);
    chk("abort_operr", OpErr, 0);
    Rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("abort_no_resp", RespValid, 0);
    end
    issue(4'b0001, 32'd0, 32'd0);
    resp("or_after_rst", 32'd0, 32'd0, 1'b1, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
